// File: rtl/stack_queue_buffer_if.sv
// Handshake bundle for stack_queue_buffer: requests, data, status.
// master = producer/consumer side, slave = buffer side.
// Optional overflow/underflow with STACK_QUEUE_ERR_FLAGS_EN.
interface stack_queue_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  mode;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  mode_q;
`ifdef STACK_QUEUE_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output mode, push, pop, din,
    input  dout, dout_valid, full, empty,
    input  almost_full, almost_empty,
    input  count, mode_q
`ifdef STACK_QUEUE_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  mode, push, pop, din,
    output dout, dout_valid, full, empty,
    output almost_full, almost_empty,
    output count, mode_q
`ifdef STACK_QUEUE_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/stack_queue_buffer.sv
// LIFO/FIFO buffer; ports: clk, rst (async active-low), bus (slave).
// STACK_QUEUE_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module stack_queue_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input logic clk,
  input logic rst,
  stack_queue_buffer_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wa, ra;
  logic [CW-1:0]         count, count_n, top_c;
  logic dout_valid, full, empty, af, ae, mode_q;
  logic pop_ok, push_ok;

  function automatic logic [ADDR_WIDTH-1:0] nxt(
    input logic [ADDR_WIDTH-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_ok  = bus.pop & ~empty;
    push_ok = bus.push & (~full | pop_ok);
    top_c   = count - CW'(1);
    count_n = count;
    if (push_ok & ~pop_ok)
      count_n = count + CW'(1);
    else if (pop_ok & ~push_ok)
      count_n = count - CW'(1);
    if (!mode_q) begin
      // push+pop overwrites the top slot just read
      ra = top_c[ADDR_WIDTH-1:0];
      wa = pop_ok ? top_c[ADDR_WIDTH-1:0]
                  : count[ADDR_WIDTH-1:0];
    end else begin
      ra = rd_ptr;
      wa = wr_ptr;
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wa] <= bus.din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
      ae         <= 1'b1;
      af         <= (AF_C == '0);
      mode_q     <= 1'b0;
    end else begin
      count      <= count_n;
      empty      <= (count_n == '0);
      full       <= (count_n == DEPTH_C);
      af         <= (count_n >= AF_C);
      ae         <= (count_n <= AE_C);
      dout_valid <= pop_ok;
      if (pop_ok) dout <= mem[ra];
      if (empty & ~push_ok) mode_q <= bus.mode;
      // pointers stay equal in LIFO mode, so a
      // later switch to FIFO starts consistent
      if (mode_q) begin
        if (push_ok) wr_ptr <= nxt(wr_ptr);
        if (pop_ok)  rd_ptr <= nxt(rd_ptr);
      end
    end
  end

  assign bus.dout         = dout;
  assign bus.dout_valid   = dout_valid;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = af;
  assign bus.almost_empty = ae;
  assign bus.count        = count;
  assign bus.mode_q       = mode_q;

`ifdef STACK_QUEUE_ERR_FLAGS_EN
  logic ovf, unf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf | (bus.push & ~push_ok);
      unf <= unf | (bus.pop & empty);
    end
  end

  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
`endif
endmodule

// File: tb/tb_stack_queue_buffer.sv
// Bench for stack_queue_buffer: DEPTH 16 and DEPTH 12 instances
// driven alike, checked each cycle against an ordered-list model.
module tb_stack_queue_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       mode = 1'b0;
  logic       push = 1'b0;
  logic       pop  = 1'b0;
  logic [7:0] din  = '0;

  int n_chk = 0;
  int n_err = 0;

  stack_queue_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b16 ();
  stack_queue_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b12 ();

  assign b16.mode = mode;
  assign b16.push = push;
  assign b16.pop  = pop;
  assign b16.din  = din;
  assign b12.mode = mode;
  assign b12.push = push;
  assign b12.pop  = pop;
  assign b12.din  = din;

  stack_queue_buffer #(
    .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4),
    .AF_THRESH(14), .AE_THRESH(2)
  ) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

  stack_queue_buffer #(
    .DATA_WIDTH(8), .DEPTH(12), .ADDR_WIDTH(4),
    .AF_THRESH(10), .AE_THRESH(2)
  ) u12 (.clk(clk), .rst(rst), .bus(b12.slave));

  // model: contents kept oldest-first in mm[i][0..sz-1]
  int         dep [2] = '{16, 12};
  int         aft [2] = '{14, 10};
  int         aet [2] = '{2, 2};
  logic [7:0] mm  [2][16];
  int         sz  [2];
  logic [7:0] md  [2];
  logic       mdv [2];
  logic       mmq [2];
  logic       mov [2];
  logic       mun [2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sz[i] = 0; md[i] = '0; mdv[i] = 1'b0;
      mmq[i] = 1'b0; mov[i] = 1'b0; mun[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    bit em, fu, pok, uok;
    em  = (sz[i] == 0);
    fu  = (sz[i] == dep[i]);
    pok = pop && !em;
    uok = push && (!fu || pok);
    if (pok) begin
      if (!mmq[i]) begin
        md[i] = mm[i][sz[i]-1];
      end else begin
        md[i] = mm[i][0];
        for (int k = 0; k < 15; k++) mm[i][k] = mm[i][k+1];
      end
      sz[i]--;
    end
    if (uok) begin
      mm[i][sz[i]] = din;
      sz[i]++;
    end
    mdv[i] = pok;
    if (em && !uok) mmq[i] = mode;
    if (push && !uok) mov[i] = 1'b1;
    if (pop && em) mun[i] = 1'b1;
  endtask

  task automatic cmp_one(input int i,
      input logic [7:0] d, input logic dv,
      input logic f, input logic e,
      input logic af, input logic ae,
      input logic [4:0] c, input logic mq,
      input logic ov, input logic un);
    string p;
    p = $sformatf("d%0d", dep[i]);
    chk({p, "_dout"}, d, md[i]);
    chk({p, "_dout_valid"}, dv, mdv[i]);
    chk({p, "_count"}, c, sz[i]);
    chk({p, "_full"}, f, sz[i] == dep[i]);
    chk({p, "_empty"}, e, sz[i] == 0);
    chk({p, "_almost_full"}, af, sz[i] >= aft[i]);
    chk({p, "_almost_empty"}, ae, sz[i] <= aet[i]);
    chk({p, "_mode_q"}, mq, mmq[i]);
`ifdef STACK_QUEUE_ERR_FLAGS_EN
    chk({p, "_overflow"}, ov, mov[i]);
    chk({p, "_underflow"}, un, mun[i]);
`else
    if (ov !== 1'b0 || un !== 1'b0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_errflags got=%b%b exp=00", p, ov, un);
    end
`endif
  endtask

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
`ifdef STACK_QUEUE_ERR_FLAGS_EN
    cmp_one(0, b16.dout, b16.dout_valid, b16.full, b16.empty,
            b16.almost_full, b16.almost_empty, b16.count,
            b16.mode_q, b16.overflow, b16.underflow);
    cmp_one(1, b12.dout, b12.dout_valid, b12.full, b12.empty,
            b12.almost_full, b12.almost_empty, b12.count,
            b12.mode_q, b12.overflow, b12.underflow);
`else
    cmp_one(0, b16.dout, b16.dout_valid, b16.full, b16.empty,
            b16.almost_full, b16.almost_empty, b16.count,
            b16.mode_q, 1'b0, 1'b0);
    cmp_one(1, b12.dout, b12.dout_valid, b12.full, b12.empty,
            b12.almost_full, b12.almost_empty, b12.count,
            b12.mode_q, 1'b0, 1'b0);
`endif
  end

  task automatic step(input logic m, input logic pu,
                      input logic po, input logic [7:0] d);
    mode = m; push = pu; pop = po; din = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    #2;
  endtask

  int pp [4] = '{70, 30, 50, 90};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_count", b16.count, 0);
    chk("rst_empty", b16.empty, 1);
    chk("rst_full", b16.full, 0);
    chk("rst_ae", b16.almost_empty, 1);
    chk("rst_af", b16.almost_full, 0);
    chk("rst_dv", b16.dout_valid, 0);
    rst = 1'b1;

    // LIFO fill and drain
    for (int k = 1; k <= 16; k++) step(0, 1, 0, 8'(k));
    chk("t1_full16", b16.full, 1);
    chk("t1_count16", b16.count, 16);
    chk("t1_count12", b12.count, 12);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 8'h00);
      chk("t1_pop", b16.dout, 16 - k);
      chk("t1_dv", b16.dout_valid, 1);
    end
    chk("t1_empty", b16.empty, 1);

    // replace-top when full, then overflow/underflow
    for (int k = 1; k <= 16; k++) step(0, 1, 0, 8'(k));
    step(0, 1, 1, 8'h55);
    chk("t3_old_top", b16.dout, 8'h10);
    chk("t3_count", b16.count, 16);
    step(0, 0, 1, 8'h00);
    chk("t3_new_top", b16.dout, 8'h55);
    step(0, 1, 0, 8'h77);
    step(0, 1, 0, 8'h88);
    chk("t5_push_full", b16.count, 16);
    for (int k = 0; k < 16; k++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("t5_pop_empty_cnt", b16.count, 0);
    chk("t5_pop_empty_dv", b16.dout_valid, 0);
`ifdef STACK_QUEUE_ERR_FLAGS_EN
    chk("t5_overflow", b16.overflow, 1);
    chk("t5_underflow", b16.underflow, 1);
`endif

    // mode change only while empty
    for (int k = 1; k <= 3; k++) step(1, 1, 0, 8'(k));
    chk("t6_mode_held", b16.mode_q, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 8'h00);
    chk("t6_lifo_last", b16.dout, 1);
    step(1, 0, 0, 8'h00);
    chk("t6_mode_fifo", b16.mode_q, 1);

    // FIFO order
    for (int k = 0; k < 5; k++) step(1, 1, 0, 8'hA0 + 8'(k));
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 8'h00);
      chk("t2_fifo_dout", b16.dout, 8'hA0 + k);
      chk("t2_fifo_dv", b16.dout_valid, 1);
    end
    step(1, 0, 0, 8'h00);
    chk("t2_dv_drop", b16.dout_valid, 0);

    // FIFO wrap with simultaneous push+pop
    for (int k = 0; k < 6; k++) step(1, 1, 0, 8'h10 + 8'(k));
    step(1, 1, 1, 8'hB0);
    chk("t4_first_out", b12.dout, 8'h10);
    for (int k = 1; k < 30; k++) step(1, 1, 1, 8'hB0 + 8'(k));
    chk("t4_count", b12.count, 6);

    // random traffic in biased phases
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 500; k++)
        step(1'($urandom_range(1)),
             $urandom_range(99) < pp[b],
             $urandom_range(99) < (100 - pp[b]),
             8'($urandom));
    end

    // asynchronous reset mid-burst
    for (int k = 0; k < 5; k++) step(mode, 1, 0, 8'($urandom));
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_count16", b16.count, 0);
    chk("rst_mid_empty16", b16.empty, 1);
    chk("rst_mid_count12", b12.count, 0);
    chk("rst_mid_mode", b16.mode_q, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    step(0, 1, 0, 8'h3C);
    step(0, 0, 1, 8'h00);
    chk("post_rst_dout", b16.dout, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
